// File: rtl/video_pixel_source.sv
`default_nettype none
// ============================================================================
// video_pixel_source - raster timing generator with prefetched RGB pixel stream
// Rev 1.0
// ============================================================================
module video_pixel_source #(
    parameter int          H_DISP        = 640,
    parameter int          H_FRONT       = 16,
    parameter int          H_SYNC        = 96,
    parameter int          H_TOTAL       = 800,
    parameter int          V_DISP        = 480,
    parameter int          V_FRONT       = 10,
    parameter int          V_SYNC        = 2,
    parameter int          V_TOTAL       = 525,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          ADDR_W        = 19,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic              rd_valid,
    input  logic [23:0]       rd_data,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
);

    localparam int XW = $clog2(H_TOTAL + 1);
    localparam int YW = $clog2(V_TOTAL + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [XW-1:0]     X_DISP    = XW'(H_DISP);
    localparam logic [XW-1:0]     X_HS_BEG  = XW'(H_DISP + H_FRONT);
    localparam logic [XW-1:0]     X_HS_END  = XW'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [XW-1:0]     X_LAST    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]     Y_DISP    = YW'(V_DISP);
    localparam logic [YW-1:0]     Y_VS_BEG  = YW'(V_DISP + V_FRONT);
    localparam logic [YW-1:0]     Y_VS_END  = YW'(V_DISP + V_FRONT + V_SYNC);
    localparam logic [YW-1:0]     Y_LAST    = YW'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISP * V_DISP - 1);
    localparam logic [CW:0]       DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DRAIN   = 2'd1,
        WAIT_VB = 2'd2
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [23:0]     r_fifo [FIFO_DEPTH];
    logic [23:0]     r_rgb;

    state_t          w_state_n;
    logic            w_active;
    logic            w_accept;
    logic            w_beat;
    logic            w_push;
    logic            w_pop;
    logic            w_uf_event;
    logic            w_flush;
    logic [CW-1:0]   w_count_n;
    logic [CW-1:0]   w_outstanding_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic [CW:0]     w_credit;

    assign red   = r_rgb[23:16];
    assign green = r_rgb[15:8];
    assign blue  = r_rgb[7:0];

    always_comb begin
        w_active   = (r_x < X_DISP) && (r_y < Y_DISP);
        w_accept   = rd_req && rd_ready;
        // A return beat with no credit outstanding is a protocol error and is dropped.
        w_beat     = rd_valid && (r_outstanding != '0);
        w_push     = w_beat && (r_state == FETCH);
        w_pop      = w_active && (r_state == FETCH) && (r_count != '0);
        w_uf_event = w_active && (r_state == FETCH) && (r_count == '0);

        w_state_n = r_state;
        w_flush   = 1'b0;
        case (r_state)
            FETCH:   if (w_uf_event) w_state_n = DRAIN;
            DRAIN:   if (r_outstanding == '0) w_state_n = WAIT_VB;
            WAIT_VB: if (r_y >= Y_DISP) begin
                         w_state_n = FETCH;
                         w_flush   = 1'b1;
                     end
            default: w_state_n = FETCH;
        endcase

        w_outstanding_n = r_outstanding;
        if (w_accept && !w_beat)
            w_outstanding_n = r_outstanding + 1'b1;
        else if (!w_accept && w_beat)
            w_outstanding_n = r_outstanding - 1'b1;

        w_count_n = r_count;
        if (w_flush)
            w_count_n = '0;
        else if (w_push && !w_pop)
            w_count_n = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_n = r_count - 1'b1;

        w_addr_n = rd_addr;
        if (w_flush)
            w_addr_n = '0;
        else if (w_accept)
            w_addr_n = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;

        // Credit uses post-edge occupancy so an issued request always has a free slot.
        w_credit = {1'b0, w_count_n} + {1'b0, w_outstanding_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FETCH;
            r_x           <= '0;
            r_y           <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rgb         <= '0;
            rd_req        <= 1'b0;
            rd_addr       <= '0;
            de            <= 1'b0;
            hsync         <= 1'b0;
            vsync         <= 1'b0;
            frame_start   <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end

            r_state       <= w_state_n;
            r_count       <= w_count_n;
            r_outstanding <= w_outstanding_n;
            rd_addr       <= w_addr_n;
            rd_req        <= (r_state == FETCH) && (w_credit < DEPTH_LIM);

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            de          <= w_active;
            hsync       <= (r_x >= X_HS_BEG) && (r_x < X_HS_END);
            vsync       <= (r_y >= Y_VS_BEG) && (r_y < Y_VS_END);
            frame_start <= (r_x == '0) && (r_y == '0);

            if (!w_active)
                r_rgb <= '0;
            else if (w_pop)
                r_rgb <= r_fifo[r_rd_ptr];
            else
                r_rgb <= UNDERFLOW_RGB;

            if (w_uf_event)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= rd_data;
    end

endmodule
`default_nettype wire
